// File: rtl/print_scheduler.sv
// print_scheduler: queues ME-stage print requests and holds each value on
// the display for a minimum number of cycles, stalling the pipe when full.
module print_scheduler #(
    parameter int VALUE_W     = 32,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                         sys_clock,
    input  logic                         reset,
    input  logic                         print_req,
    input  logic [VALUE_W-1:0]           print_value,
    input  logic                         print_clear,
    output logic                         print_stall,
    output logic [VALUE_W-1:0]           disp_value,
    output logic                         disp_valid,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SHOW   = 2'd1,
        PARKED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [HLD_W-1:0]     hold_q, hold_d;
    logic [VALUE_W-1:0]   value_q, value_d;
    logic                 valid_q, valid_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [VALUE_W-1:0]   mem_q [DEPTH];

    logic full;
    logic nonempty;
    logic push;
    logic pop;

    assign full        = (count_q == FULL);
    assign nonempty    = (count_q != '0);
    assign push        = print_req && !full && !print_clear;
    assign print_stall = full;
    assign busy        = (state_q == SHOW) || nonempty;
    assign fifo_count  = count_q;
    assign disp_value  = value_q;
    assign disp_valid  = valid_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        value_d = value_q;
        valid_d = valid_q;
        pop     = 1'b0;
        unique case (state_q)
            EMPTY, PARKED: pop = nonempty;
            SHOW: begin
                if (hold_q == HOLD_LAST) begin
                    pop = nonempty;
                    if (!nonempty) state_d = PARKED;
                end else begin
                    hold_d = hold_q + HLD_W'(1);
                end
            end
            default: state_d = EMPTY;
        endcase
        if (pop) begin
            value_d = mem_q[rptr_q];
            valid_d = 1'b1;
            hold_d  = '0;
            state_d = SHOW;
        end
        // clear wins over everything, including a pop due this edge
        if (print_clear) begin
            pop     = 1'b0;
            state_d = EMPTY;
            hold_d  = '0;
            value_d = '0;
            valid_d = 1'b0;
        end

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (print_clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            hold_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            value_q <= value_d;
            valid_q <= valid_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (push) mem_q[wptr_q] <= print_value;
    end

endmodule

// File: tb/tb_print_scheduler.sv
// Bench for print_scheduler: timeline reference model feeding a display
// scoreboard, plus per-cycle occupancy/stall/busy checks.
module tb_print_scheduler;

    localparam int VW    = 32;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          sys_clock = 1'b0;
    logic          reset = 1'b1;
    logic          print_req = 1'b0;
    logic [VW-1:0] print_value = '0;
    logic          print_clear = 1'b0;
    logic          print_stall;
    logic [VW-1:0] disp_value;
    logic          disp_valid;
    logic          busy;
    logic [CW-1:0] fifo_count;

    print_scheduler #(
        .VALUE_W    (VW),
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .sys_clock  (sys_clock),
        .reset      (reset),
        .print_req  (print_req),
        .print_value(print_value),
        .print_clear(print_clear),
        .print_stall(print_stall),
        .disp_value (disp_value),
        .disp_valid (disp_valid),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [VW-1:0] v;
        int            start;
    } ent_t;

    int            checks = 0;
    int            fails = 0;
    int            edge_n = 0;
    int            last_start = -1000;
    int            cur_start = -1000;
    logic          cur_valid = 1'b0;
    logic [VW-1:0] cur_val = '0;
    int            exp_count = 0;
    bit            last_acc = 1'b0;
    logic [7:0]    seq = '0;
    ent_t          pend[$];
    ent_t          sb[$];
    ent_t          mon_e;
    logic          prev_valid = 1'b0;
    logic [VW-1:0] prev_value = '0;
    bit            have;
    logic [VW-1:0] hold_v;
    bit            clr;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    function automatic void model_flush();
        pend.delete();
        sb.delete();
        cur_valid  = 1'b0;
        cur_val    = '0;
        cur_start  = -1000;
        last_start = -1000;
        exp_count  = 0;
    endfunction

    // Each accepted value starts one edge after acceptance, but never
    // before its predecessor has been shown for HOLD cycles.
    function automatic void model_edge(bit r, logic [VW-1:0] v, bit c);
        ent_t e;
        last_acc = 1'b0;
        if (c) begin
            model_flush();
            return;
        end
        if (r && pend.size() < DEPTH) begin
            e.v     = v;
            e.start = (edge_n + 1 > last_start + HOLD) ? edge_n + 1
                                                       : last_start + HOLD;
            last_start = e.start;
            pend.push_back(e);
            sb.push_back(e);
            last_acc = 1'b1;
        end
        if (pend.size() != 0 && pend[0].start == edge_n) begin
            cur_val   = pend[0].v;
            cur_valid = 1'b1;
            cur_start = edge_n;
            void'(pend.pop_front());
        end
        exp_count = pend.size();
    endfunction

    function automatic logic [VW-1:0] nextv();
        logic [31:0] t;
        t   = $urandom();
        seq = seq + 8'd1;
        return {t[31:8], seq};
    endfunction

    task automatic step(bit r, logic [VW-1:0] v, bit c);
        print_req   = r;
        print_value = v;
        print_clear = c;
        @(posedge sys_clock);
        edge_n++;
        model_edge(r, v, c);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom(), 1'b0);
    endtask

    task automatic send(logic [VW-1:0] v);
        int n;
        n = 0;
        do begin
            step(1'b1, v, 1'b0);
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) begin
            fails++;
            $display("FAIL send_timeout: got no accept expected accept for %0h", v);
        end
    endtask

    always @(negedge sys_clock) begin
        chk("disp_valid", disp_valid, cur_valid);
        chk("disp_value", disp_value, cur_val);
        chk("fifo_count", fifo_count, exp_count);
        chk("print_stall", print_stall, exp_count == DEPTH);
        chk("busy", busy,
            (exp_count != 0) || (cur_valid && edge_n < cur_start + HOLD));
        if (disp_valid && (!prev_valid || disp_value != prev_value)) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_display: got %0h expected none",
                         disp_value);
            end else begin
                mon_e = sb.pop_front();
                chk("disp_order", disp_value, mon_e.v);
                chk("disp_edge", edge_n, mon_e.start);
            end
        end
        prev_valid = disp_valid;
        prev_value = disp_value;
    end

    initial begin
        model_flush();
        repeat (2) @(posedge sys_clock);
        #2;
        chk("reset_valid", disp_valid, 1'b0);
        chk("reset_value", disp_value, '0);
        chk("reset_count", fifo_count, '0);
        chk("reset_busy", busy, 1'b0);
        reset = 1'b0;

        send(32'h2A);
        idle(8);

        for (int i = 0; i < 6; i++) send(nextv());
        idle(30);

        for (int i = 0; i < 4; i++) send(nextv());
        step(1'b1, 32'h77, 1'b1);
        chk("clear_count", fifo_count, '0);
        chk("clear_valid", disp_valid, 1'b0);
        chk("clear_value", disp_value, '0);
        idle(10);

        for (int i = 0; i < 3; i++) send(nextv());
        #2;
        reset = 1'b1;
        model_flush();
        #1;
        chk("amid_valid", disp_valid, 1'b0);
        chk("amid_value", disp_value, '0);
        chk("amid_count", fifo_count, '0);
        chk("amid_busy", busy, 1'b0);
        reset = 1'b0;
        send(nextv());
        idle(8);

        for (int i = 0; i < 10; i++) begin
            send(nextv());
            idle(3);
        end
        idle(8);

        have = 1'b0;
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 39) == 0);
            if (!have && $urandom_range(0, 99) < 55) begin
                have   = 1'b1;
                hold_v = nextv();
            end
            step(have, have ? hold_v : $urandom(), clr);
            if (last_acc || clr) have = 1'b0;
        end
        idle(40);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/print_scheduler.md
# print_scheduler

Sequences `HEX0`–`HEX5` print requests coming out of the ME stage. Each value is held on the display for a programmable minimum time, and requests that arrive faster than that are buffered in a small FIFO. The pipeline is back-pressured with a stall when the FIFO is full. The block sits between the ME stage's `r_me_aluout`/`r_me_PrintValue` and the `valueToDisplay` instance, and replaces the direct connection.

## Interface
Parameters:
- `VALUE_W`, default 32: width of a printed value.
- `DEPTH`, default 4: FIFO entries, ≥2, power of two.
- `HOLD_CYCLES`, default 50_000_000: minimum cycles each value stays displayed, ≥1.

Ports:
- `sys_clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `print_req`, in, 1: print request from ME.
- `print_value`, in, `VALUE_W`: value to print; sampled with `print_req`.
- `print_clear`, in, 1: synchronous flush of queue and display.
- `print_stall`, out, 1: FIFO full; a request is not accepted and must be held.
- `disp_value`, out, `VALUE_W`: value driven to `valueToDisplay.value`.
- `disp_valid`, out, 1: drives `valueToDisplay.print_it`.
- `busy`, out, 1: a hold is in progress or the FIFO is non-empty.
- `fifo_count`, out, `$clog2(DEPTH+1)`: current occupancy.

## Operation
- **Reset:** all outputs are 0, the FIFO is empty, the hold counter is 0, and the state is `EMPTY`.
- **Accept rule:** a request is enqueued at a rising edge where `print_req=1`, `print_stall=0` and `print_clear=0`.
- **Stall:** `print_stall = (fifo_count == DEPTH)`, registered-state based.
  - A pop in the same cycle does not un-stall that cycle; the request is rejected and must be retried.
- **States:**
  - `EMPTY`: nothing displayed; `disp_valid=0`.
  - `SHOW`: a value is displayed and the hold counter is running.
  - `PARKED`: the hold has expired and the FIFO is empty; the last value stays displayed with `disp_valid=1`.
- **Pop:** loads the FIFO head into `disp_value`, sets `disp_valid=1`, clears the hold counter to 0 and enters `SHOW`, all on the same edge.
- **EMPTY/PARKED:** if `fifo_count≠0`, pop.
- **SHOW:** the counter increments each cycle. At the edge where counter == `HOLD_CYCLES-1`:
  - if the FIFO is non-empty, pop the next value (back-to-back, no gap);
  - otherwise go to `PARKED`.
- **Simultaneous push and pop:** allowed when not full; occupancy is unchanged.
- **`print_clear`:**
  - Priority: it overrides push and pop.
  - Effect: FIFO emptied, `disp_value=0`, `disp_valid=0`, counter 0, state `EMPTY`.
  - A concurrent request is dropped.
- **FIFO:** read/write pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
- **`busy`:** `(state==SHOW) || (fifo_count≠0)`.

## Timing
- **Latency:** a request accepted at edge k while in `EMPTY`/`PARKED` appears on `disp_value`/`disp_valid` after edge k+1 (2-cycle latency). No combinational bypass.
- **Hold length:** every popped value is displayed for exactly `HOLD_CYCLES` cycles when a successor is queued; otherwise it stays displayed indefinitely.
- **Outputs:** all registered, except `print_stall` and `busy`, which are decoded from registered state only. No input-to-output combinational path.
- **Reset mid-operation:** asynchronous. All state is cleared immediately and queued values are lost.

## Test plan
All scenarios use `HOLD_CYCLES=4`, `DEPTH=4`.
- **Single print:** `print_req` with `0x2A` at edge 0 → `disp_value=0x2A`, `disp_valid=1` after edge 1. State goes `SHOW`→`PARKED` at edge 5; the value is still shown and `busy=0` after edge 5.
- **Burst with stall:** values A–F requested on consecutive edges 0–5.
  - Required fill: A popped at edge 1; E makes `fifo_count=4` at edge 4.
  - Required stall: `print_stall=1` during cycle 4→5, so F is rejected at edge 5 and accepted at edge 6.
  - Required display: A, B, C, D, E, F, each for exactly 4 cycles, with pops at edges 1, 5, 9, 13, 17, 21.
- **Full + pop same edge:** FIFO full and hold expiring at edge n, with a request at edge n → request rejected, `fifo_count` drops to 3. The retried request is accepted at edge n+1.
- **Clear with concurrent request:** FIFO holding 3 values; `print_clear=1` together with `print_req` carrying `0x77` → after the edge, `fifo_count=0`, `disp_valid=0`, `disp_value=0`, and `0x77` is never displayed.
- **Reset mid-operation:** assert `reset` between edges while in `SHOW` with 2 queued → outputs go to 0 immediately, without waiting for an edge. After release, a new request displays after 2 edges.
- **Pointer wrap:** 10 requests spaced 4 cycles apart → all 10 values are displayed in order. `fifo_count` never exceeds 1 and pointers wrap without corruption.
